ctrl_seq: RTL and testbench

- Parametrised multi-cycle fetch/execute controller; successor to the single-cycle fetch loop in ctrl.
- Sits between the memory module and (later) the ALU.
- Holds the register file, with the last register as PC.
- Adds a wait-state memory handshake, operand fetch, load/store, branching, halt and a debug read port.

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/ctrl_seq_if.sv | 17 +
 rtl/ctrl_regfile.sv | 38 +++
 rtl/ctrl_seq.sv | 101 ++++++++++
 tb/tb_ctrl_seq.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, state and instruction-field definitions for the ctrl_seq controller.
package ctrl_pkg;

  localparam int OP_W = 3;  // opcode field width, sits at the top of the word

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_LDI = 3'b001;
  localparam logic [OP_W-1:0] OP_LD  = 3'b010;
  localparam logic [OP_W-1:0] OP_ST  = 3'b011;
  localparam logic [OP_W-1:0] OP_JMP = 3'b100;
  localparam logic [OP_W-1:0] OP_BZ  = 3'b101;
  localparam logic [OP_W-1:0] OP_INC = 3'b110;
  localparam logic [OP_W-1:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH, ST_OPERAND, ST_DATA, ST_EXEC, ST_HALT
  } state_t;

  // Opcodes that carry a trailing operand word.
  function automatic logic need_operand(input logic [OP_W-1:0] op);
    return op inside {OP_LDI, OP_LD, OP_ST, OP_JMP, OP_BZ};
  endfunction

  // Opcodes that perform a data-memory beat.
  function automatic logic need_data(input logic [OP_W-1:0] op);
    return op inside {OP_LD, OP_ST};
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Memory handshake bundle between the controller (master) and memory (slave).
interface ctrl_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] from_mem;
  logic [DATA_WIDTH-1:0] to_mem;
  logic                  mem_clock;
  logic                  mem_write;
  logic                  mem_ready;

  modport master (output address, to_mem, mem_clock, mem_write,
                  input  from_mem, mem_ready);
  modport slave  (input  address, to_mem, mem_clock, mem_write,
                  output from_mem, mem_ready);
endinterface

// File: rtl/ctrl_regfile.sv
// Register file; the last register is the PC, kept masked to ADDR_WIDTH bits.
module ctrl_regfile import ctrl_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_COUNT  = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [$clog2(REG_COUNT)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         pc_inc,
  input  logic [$clog2(REG_COUNT)-1:0] rd_sel,
  input  logic [$clog2(REG_COUNT)-1:0] dbg_sel,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [DATA_WIDTH-1:0]        dbg_data,
  output logic [ADDR_WIDTH-1:0]        pc
);
  localparam int RW = $clog2(REG_COUNT);
  localparam logic [RW-1:0]         PC_IDX  = RW'(REG_COUNT - 1);
  localparam logic [DATA_WIDTH-1:0] PC_MASK = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - ADDR_WIDTH);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;

  assign rd_data  = regs[rd_sel];
  assign dbg_data = regs[dbg_sel];
  assign pc       = regs[PC_IDX][ADDR_WIDTH-1:0];

  // Single write port; an explicit write beats the sequential PC increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      regs <= '0;
    else if (wr_en)
      regs[wr_addr] <= (wr_addr == PC_IDX) ? (wr_data & PC_MASK) : wr_data;
    else if (pc_inc)
      regs[PC_IDX] <= (regs[PC_IDX] + DATA_WIDTH'(1)) & PC_MASK;
  end
endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/operand/data/exec controller with wait-state memory handshake.
module ctrl_seq import ctrl_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_COUNT  = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  ctrl_seq_if.master                   bus,
  output logic                         halted,
  input  logic [$clog2(REG_COUNT)-1:0] dbg_sel,
  output logic [DATA_WIDTH-1:0]        dbg_data
);
  localparam int RW  = $clog2(REG_COUNT);
  localparam int IRW = OP_W + RW;  // only opcode and rd are kept from the instruction
  localparam logic [RW-1:0] PC_IDX = RW'(REG_COUNT - 1);

  state_t                state_q, state_d;
  logic [IRW-1:0]        ir_q, ir_d;
  logic [DATA_WIDTH-1:0] opr_q, opr_d, hold_q, hold_d;
  logic [OP_W-1:0]       op;
  logic [RW-1:0]         rd;
  logic                  wr_en, pc_inc, mem_req, mem_wr;
  logic [RW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_data;
  logic [ADDR_WIDTH-1:0] pc;

  assign op = ir_q[IRW-1 -: OP_W];
  assign rd = ir_q[RW-1:0];

  ctrl_regfile #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .REG_COUNT(REG_COUNT)) u_rf (
    .clock, .reset_n, .wr_en, .wr_addr, .wr_data, .pc_inc,
    .rd_sel(rd), .dbg_sel, .rd_data, .dbg_data, .pc
  );

  // Memory-side outputs depend only on registered state; reset_n gating drops the strobe
  // asynchronously so a beat in flight is abandoned the moment reset asserts.
  assign mem_req       = state_q inside {ST_FETCH, ST_OPERAND, ST_DATA};
  assign mem_wr        = (state_q == ST_DATA) && (op == OP_ST);
  assign bus.mem_clock = mem_req & reset_n;
  assign bus.mem_write = mem_wr & reset_n;
  assign bus.address   = (state_q == ST_DATA) ? opr_q[ADDR_WIDTH-1:0] : pc;
  assign bus.to_mem    = mem_wr ? rd_data : '0;
  assign halted        = (state_q == ST_HALT);

  // State, instruction, operand and load-holding registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      opr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and register-file control; memory states stall while mem_ready is low.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    hold_d  = hold_q;
    pc_inc  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = '0;
    case (state_q)
      ST_FETCH: if (bus.mem_ready) begin
        ir_d    = bus.from_mem[DATA_WIDTH-1 -: IRW];
        pc_inc  = 1'b1;
        state_d = need_operand(bus.from_mem[DATA_WIDTH-1 -: OP_W]) ? ST_OPERAND : ST_EXEC;
      end
      ST_OPERAND: if (bus.mem_ready) begin
        opr_d   = bus.from_mem;
        pc_inc  = 1'b1;
        state_d = need_data(op) ? ST_DATA : ST_EXEC;
      end
      ST_DATA: if (bus.mem_ready) begin
        if (op == OP_LD) hold_d = bus.from_mem;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = (op == OP_HLT) ? ST_HALT : ST_FETCH;
        case (op)
          OP_LDI: begin wr_en = 1'b1; wr_data = opr_q; end
          OP_LD:  begin wr_en = 1'b1; wr_data = hold_q; end
          OP_INC: begin wr_en = 1'b1; wr_data = rd_data + DATA_WIDTH'(1); end
          OP_JMP: begin wr_en = 1'b1; wr_addr = PC_IDX; wr_data = opr_q; end
          OP_BZ:  begin wr_en = (rd_data == '0); wr_addr = PC_IDX; wr_data = opr_q; end
          default: ;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end
endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: an instruction-level model predicts every memory beat,
// the cycle count and the final register file for each small program.
module tb_ctrl_seq;
  typedef struct { logic [7:0] a; logic w; logic [7:0] d; } beat_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rdy;
  logic [2:0] dbg_sel;
  logic [7:0] dbg_data;
  logic       halted;
  logic [7:0] mem  [256];
  logic [7:0] mmem [256];
  logic [7:0] m_reg [8];
  int         m_cycles;
  beat_t      exp_q [$];
  bit         chk_en;
  int         pass_cnt = 0, total_cnt = 0;

  ctrl_seq_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ctrl_seq #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .REG_COUNT(8)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  assign bus.from_mem  = mem[bus.address];
  assign bus.mem_ready = rdy;

  always @(posedge clock)
    if (reset_n && bus.mem_clock && bus.mem_ready && bus.mem_write) mem[bus.address] = bus.to_mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Every strobed cycle must present the next predicted beat; it retires when mem_ready is high.
  always @(negedge clock) begin
    if (chk_en && reset_n && bus.mem_clock) begin
      if (exp_q.size() == 0) chk("extra_beat", {24'h0, bus.address}, 32'hFFFF);
      else begin
        chk("beat_addr", bus.address, exp_q[0].a);
        chk("beat_wr", bus.mem_write, exp_q[0].w);
        if (exp_q[0].w) chk("beat_data", bus.to_mem, exp_q[0].d);
        if (rdy) void'(exp_q.pop_front());
      end
    end
  end

  // Instruction-set interpreter over a private copy of memory.
  task automatic run_model();
    logic [7:0] r [8];
    logic [7:0] ir, opr;
    logic [2:0] op, rd;
    bit halt = 0;
    int steps = 0;
    for (int i = 0; i < 256; i++) mmem[i] = mem[i];
    for (int i = 0; i < 8; i++) r[i] = 8'h00;
    exp_q.delete();
    m_cycles = 0;
    opr = 8'h00;
    while (!halt && steps < 300) begin
      steps++;
      exp_q.push_back('{a: r[7], w: 1'b0, d: 8'h00});
      ir = mmem[r[7]]; r[7] = r[7] + 8'd1;
      op = ir[7:5]; rd = ir[4:2];
      m_cycles += 2;
      if (op >= 3'd1 && op <= 3'd5) begin
        exp_q.push_back('{a: r[7], w: 1'b0, d: 8'h00});
        opr = mmem[r[7]]; r[7] = r[7] + 8'd1;
        m_cycles++;
      end
      case (op)
        3'd1: r[rd] = opr;
        3'd2: begin exp_q.push_back('{a: opr, w: 1'b0, d: 8'h00}); r[rd] = mmem[opr]; m_cycles++; end
        3'd3: begin exp_q.push_back('{a: opr, w: 1'b1, d: r[rd]}); mmem[opr] = r[rd]; m_cycles++; end
        3'd4: r[7] = opr;
        3'd5: if (r[rd] == 8'h00) r[7] = opr;
        3'd6: r[rd] = r[rd] + 8'd1;
        3'd7: halt = 1;
        default: ;
      endcase
    end
    for (int i = 0; i < 8; i++) m_reg[i] = r[i];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; rdy = 1'b1; dbg_sel = 3'd7;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_clock", bus.mem_clock, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_address", bus.address, 8'h00);
    chk("rst_to_mem", bus.to_mem, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_pc", dbg_data, 8'h00);
    reset_n = 1'b1;
  endtask

  // Run the loaded program to HALT with mem_ready low for the first wlen edges.
  task automatic run_prog(input string tag, input int wlen, input int lit_cycles, output int n);
    bit done = 0;
    run_model();
    chk({tag, "_model_cycles"}, m_cycles, lit_cycles);
    do_reset();
    chk_en = 1;
    n = 0;
    while (!done && n < 400) begin
      rdy = (n >= wlen);
      @(posedge clock); #1;
      n++;
      if (halted) done = 1;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_cycles"}, n, m_cycles + wlen);
    rdy = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk({tag, "_halt_strobe"}, bus.mem_clock, 1'b0);
    chk({tag, "_halted"}, halted, 1'b1);
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk_en = 0;
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i); #1;
      chk({tag, "_reg"}, dbg_data, m_reg[i]);
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0; rdy = 1'b1; dbg_sel = 3'd0; chk_en = 0;

    // NOP; HLT
    clear_mem(); mem[0] = 8'h00; mem[1] = 8'hE0;
    run_prog("nop_hlt", 0, 4, n);
    chk("nop_hlt_lit_cycles", n, 4);

    // LDI r2,#A5; ST r2,[40]; HLT
    clear_mem();
    mem[0] = 8'h28; mem[1] = 8'hA5; mem[2] = 8'h68; mem[3] = 8'h40; mem[4] = 8'hE0;
    run_prog("ldi_st", 0, 9, n);
    chk("st_mem40", mem[8'h40], 8'hA5);
    dbg_sel = 3'd2; #1;
    chk("st_dbg_r2", dbg_data, 8'hA5);

    // LD r1,[10]; HLT with three wait cycles on the first fetch
    clear_mem();
    mem[0] = 8'h44; mem[1] = 8'h10; mem[2] = 8'hE0; mem[8'h10] = 8'h3C;
    run_prog("ld_wait", 3, 6, n);
    chk("ld_wait_lit_cycles", n, 9);
    dbg_sel = 3'd1; #1;
    chk("ld_dbg_r1", dbg_data, 8'h3C);

    // BZ r3,20 taken (r3=0)
    clear_mem();
    mem[0] = 8'hAC; mem[1] = 8'h20;
    run_prog("bz_taken", 0, 5, n);
    dbg_sel = 3'd7; #1;
    chk("bz_taken_pc", dbg_data, 8'h21);

    // INC r3; BZ r3,20 not taken; HLT at 3
    clear_mem();
    mem[0] = 8'hCC; mem[1] = 8'hAC; mem[2] = 8'h20;
    run_prog("bz_not", 0, 7, n);
    dbg_sel = 3'd7; #1;
    chk("bz_not_pc", dbg_data, 8'h04);

    // PC wrap: 0 NOP; 1 BZ r1,10; 10 INC r1; 11 LDI r7,#FE; FE/FF/00 NOP; 1 BZ not taken; 3 HLT
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'hA4; mem[2] = 8'h10;
    mem[8'h10] = 8'hC4; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFE;
    mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h00;
    run_prog("pc_wrap", 0, 21, n);
    dbg_sel = 3'd7; #1;
    chk("pc_wrap_pc", dbg_data, 8'h04);

    // Reset asserted while the ST data beat is stalled
    clear_mem();
    mem[0] = 8'h28; mem[1] = 8'h77; mem[2] = 8'h68; mem[3] = 8'h40; mem[8'h40] = 8'h11;
    run_model();
    do_reset();
    chk_en = 1;
    repeat (5) @(posedge clock);
    #1; rdy = 1'b0;
    @(posedge clock); #1;
    chk("midst_strobe", bus.mem_clock, 1'b1);
    chk("midst_write", bus.mem_write, 1'b1);
    chk("midst_addr", bus.address, 8'h40);
    reset_n = 1'b0; #1;
    chk_en = 0; exp_q.delete();
    chk("midst_rst_strobe", bus.mem_clock, 1'b0);
    chk("midst_rst_write", bus.mem_write, 1'b0);
    rdy = 1'b1;
    @(posedge clock); #1;
    chk("midst_mem40", mem[8'h40], 8'h11);
    dbg_sel = 3'd2; #1;
    chk("midst_r2", dbg_data, 8'h00);
    reset_n = 1'b1; #1;
    chk("midst_restart_addr", bus.address, 8'h00);
    chk("midst_restart_strobe", bus.mem_clock, 1'b1);
    @(posedge clock); #1;
    chk("midst_second_fetch", bus.address, 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
